conware_board_streamer: RTL and testbench
=========================================

CONWARE_BOARD_STREAMER -- requirements
Module: conware_board_streamer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, AXI-stream pixel width.
REQ-002 SHALL have parameter WIDTH, default 32, cells per row.
REQ-003 SHALL have parameter HEIGHT, default 32, rows per board.
REQ-004 SHALL have parameter ALIVE_COLOR, default 'h00FFFFFF, pixel value for a live cell.
REQ-005 SHALL have parameter DEAD_COLOR, default 'h00000000, pixel value for a dead cell.
REQ-006 SHALL use one clock and a synchronous active-high reset: ACLK input 1, the clock; ARESET input 1, synchronous active-high reset.
REQ-007 seed_we  input  1  writes seed_data into row seed_row of the current board.
REQ-008 seed_row  input  $clog2(HEIGHT)  seed row index.
REQ-009 seed_data  input  WIDTH  seed row; bit c is column c.
REQ-010 start  input  1  one-cycle request to run one generation.
REQ-011 rd_row  input  $clog2(HEIGHT)  readback row index; rd_data  output  WIDTH  current board row rd_row, combinational.
REQ-012 busy  output  1; gen_done  output  1; generation  output  16; frame_err  output  1, sticky.
REQ-013 M_AXIS_TVALID out 1, M_AXIS_TREADY in 1, M_AXIS_TDATA out DWIDTH, M_AXIS_TLAST out 1: cells to the conware core.
REQ-014 S_AXIS_TVALID in 1, S_AXIS_TREADY out 1, S_AXIS_TDATA in DWIDTH, S_AXIS_TLAST in 1: next-generation pixels from the core.

Function
REQ-015 SHALL hold two HEIGHT x WIDTH bit boards, current and next.
REQ-016 FSM states SHALL be IDLE, RUN and SWAP; start in IDLE -> RUN, with busy high from the next cycle.
REQ-017 In RUN, the TX engine SHALL assert M_AXIS_TVALID from the first RUN cycle and emit pixels in row-major order, row 0 first, column 0 first.
REQ-018 TDATA SHALL be ALIVE_COLOR when the cell is 1 and DEAD_COLOR otherwise; TLAST SHALL be 1 exactly on column WIDTH-1.
REQ-019 TX SHALL advance only on TVALID&&TREADY; TDATA and TLAST SHALL stay stable while TVALID&&!TREADY.
REQ-020 TX SHALL drop TVALID the cycle after the last pixel (row HEIGHT-1, column WIDTH-1) is accepted.
REQ-021 The RX engine SHALL hold S_AXIS_TREADY=1 in RUN until HEIGHT rows are captured, then 0; outside RUN it SHALL be 0.
REQ-022 RX SHALL decode a cell as 1 iff TDATA != DEAD_COLOR and write it to next[row][col] on each handshake.
REQ-023 TX and RX SHALL run concurrently and independently; no ordering between the two is assumed.
REQ-024 On TLAST at col < WIDTH-1, RX SHALL set frame_err, leave the remaining columns of that row 0, and advance to the next row, col 0.
REQ-025 At col WIDTH-1 without TLAST, RX SHALL set frame_err and still advance to the next row.
REQ-026 When TX and RX are both complete, FSM SHALL go RUN -> SWAP, copy next into current, and clear next.
REQ-027 In SWAP, FSM SHALL increment generation (mod 2^16), pulse gen_done for 1 cycle, and return to IDLE with busy low on the following cycle.
REQ-028 start while busy SHALL be ignored; seed_we while busy SHALL be ignored.
REQ-029 If seed_we and start occur in the same IDLE cycle, the seed write SHALL take effect before TX reads the row.
REQ-030 frame_err SHALL clear only on ARESET or on an accepted start.

Reset
REQ-031 ARESET SHALL, in the next cycle, force: FSM to IDLE; both boards to 0; generation=0; busy, gen_done, frame_err, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY to 0; M_AXIS_TDATA to DEAD_COLOR.
REQ-032 ARESET mid-RUN SHALL abandon the frame with no gen_done and no partial swap.

Structure
REQ-033 A shared package conware_pkg SHALL hold the FSM state enumeration and the default ALIVE_COLOR/DEAD_COLOR constants.
REQ-034 The RX pixel-capture and alignment logic SHALL be one sub-module, conware_row_capture.

Verification (WIDTH=4, HEIGHT=2)
REQ-035 Seed row0=4'b0101, row1=0, start, TREADY=1 -> TDATA sequence FFFFFF,0,FFFFFF,0 (TLAST on 4th), then 0,0,0,0 (TLAST on 8th).
REQ-036 Same as REQ-035 with M_AXIS_TREADY toggling every cycle -> identical 8-pixel sequence, with TDATA unchanged during every stall.
REQ-037 Return stream 0,FFFFFF,0,FFFFFF|L,0,0,0,0|L -> gen_done pulses once, generation=1, rd_data(row0)=4'b1010, frame_err=0.
REQ-038 Return TLAST on pixel 3 of row0 -> frame_err=1, row0 col3 reads 0, and the next pixel is written to row1 col0.
REQ-039 start asserted again mid-RUN -> ignored (generation=1 after completion); ARESET mid-RUN -> TVALID=0, generation=0, rd_data=0 next cycle.
REQ-040 Preset generation to 16'hFFFF and run one generation -> generation=0, gen_done pulses once.

Source files
------------

// File: rtl/conware_pkg.sv
// conware_pkg: shared types and colour defaults for the conware board streamer.
// Imported by the streamer top and its row-capture sub-module.
package conware_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SWAP = 2'd2
  } state_t;

  localparam logic [31:0] ALIVE_COLOR_DEF = 32'h00FF_FFFF;
  localparam logic [31:0] DEAD_COLOR_DEF  = 32'h0000_0000;

endpackage

// File: rtl/conware_row_capture.sv
// conware_row_capture: decodes returned pixels into cell bits and keeps the
// row/column alignment, flagging rows whose TLAST is misplaced.
module conware_row_capture
  import conware_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter logic [DWIDTH-1:0] DEAD_COLOR = DWIDTH'(DEAD_COLOR_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  input  logic                      s_valid,
  input  logic [DWIDTH-1:0]         s_data,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic                      wr_en,
  output logic [$clog2(HEIGHT)-1:0] wr_row,
  output logic [$clog2(WIDTH)-1:0]  wr_col,
  output logic                      wr_bit,
  output logic                      done,
  output logic                      frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          at_end;
  logic          row_end;
  logic          misaligned;

  assign s_ready    = run && !done;
  assign wr_en      = s_valid && s_ready;
  assign wr_row     = row;
  assign wr_col     = col;
  assign wr_bit     = (s_data != DEAD_COLOR);
  assign at_end     = (col == COL_LAST);
  assign row_end    = s_last || at_end;
  // Early TLAST or a missing TLAST both close the row.
  assign misaligned = s_last ^ at_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else if (clear) begin
      row       <= '0;
      col       <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else if (wr_en) begin
      if (misaligned) begin
        frame_err <= 1'b1;
      end
      if (row_end) begin
        col <= '0;
        if (row == ROW_LAST) begin
          done <= 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conware_board_streamer.sv
// conware_board_streamer: streams the current Life board to the conware core
// and captures the next generation it returns, then swaps boards.
module conware_board_streamer
  import conware_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter logic [DWIDTH-1:0] ALIVE_COLOR = DWIDTH'(ALIVE_COLOR_DEF),
  parameter logic [DWIDTH-1:0] DEAD_COLOR  = DWIDTH'(DEAD_COLOR_DEF)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      seed_we,
  input  logic [$clog2(HEIGHT)-1:0] seed_row,
  input  logic [WIDTH-1:0]          seed_data,
  input  logic                      start,
  input  logic [$clog2(HEIGHT)-1:0] rd_row,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      busy,
  output logic                      gen_done,
  output logic [15:0]               generation,
  output logic                      frame_err,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic [DWIDTH-1:0]         M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic [DWIDTH-1:0]         S_AXIS_TDATA,
  input  logic                      S_AXIS_TLAST
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  state_t state_q;
  state_t state_d;
  logic   run;
  logic   accept;

  logic [WIDTH-1:0] cur [HEIGHT];
  logic [WIDTH-1:0] nxt [HEIGHT];
  logic [15:0]      gen_count;

  logic [RW-1:0] tx_row;
  logic [CW-1:0] tx_col;
  logic          tx_done;
  logic          tx_valid;
  logic          tx_cell;

  logic          rx_done;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic          wr_bit;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (tx_done && rx_done) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    gen_done = 1'b0;
    run      = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: accept = start;
      RUN: begin
        busy = 1'b1;
        run  = 1'b1;
      end
      SWAP: begin
        busy     = 1'b1;
        gen_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Seeds land on the same edge that launches RUN, so TX sees them.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int r = 0; r < HEIGHT; r++) begin
        cur[r] <= '0;
        nxt[r] <= '0;
      end
    end else if (gen_done) begin
      for (int r = 0; r < HEIGHT; r++) begin
        cur[r] <= nxt[r];
        nxt[r] <= '0;
      end
    end else begin
      if (seed_we && !busy) begin
        cur[seed_row] <= seed_data;
      end
      if (wr_en) begin
        nxt[wr_row][wr_col] <= wr_bit;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gen_count <= '0;
    end else if (gen_done) begin
      gen_count <= gen_count + 16'd1;
    end
  end

  assign generation = gen_count;
  assign rd_data    = cur[rd_row];

  assign tx_valid = run && !tx_done;
  assign tx_cell  = cur[tx_row][tx_col];

  assign M_AXIS_TVALID = tx_valid;
  assign M_AXIS_TDATA  = (tx_valid && tx_cell) ? ALIVE_COLOR : DEAD_COLOR;
  assign M_AXIS_TLAST  = tx_valid && (tx_col == COL_LAST);

  always_ff @(posedge ACLK) begin
    if (ARESET || accept) begin
      tx_row  <= '0;
      tx_col  <= '0;
      tx_done <= 1'b0;
    end else if (tx_valid && M_AXIS_TREADY) begin
      if (tx_col == COL_LAST) begin
        tx_col <= '0;
        if (tx_row == ROW_LAST) begin
          tx_done <= 1'b1;
        end else begin
          tx_row <= tx_row + 1'b1;
        end
      end else begin
        tx_col <= tx_col + 1'b1;
      end
    end
  end

  conware_row_capture #(
    .DWIDTH     (DWIDTH),
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .DEAD_COLOR (DEAD_COLOR)
  ) u_capture (
    .clk       (ACLK),
    .rst       (ARESET),
    .clear     (accept),
    .run       (run),
    .s_valid   (S_AXIS_TVALID),
    .s_data    (S_AXIS_TDATA),
    .s_last    (S_AXIS_TLAST),
    .s_ready   (S_AXIS_TREADY),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_bit    (wr_bit),
    .done      (rx_done),
    .frame_err (frame_err)
  );

endmodule

// File: tb/tb_conware_board_streamer.sv
// tb_conware_board_streamer: random and directed generations on a 4x2 board,
// checked against a board-level model kept in the bench.
module tb_conware_board_streamer;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam logic [31:0] ALIVE = 32'h00FF_FFFF;
  localparam logic [31:0] DEAD  = 32'h0;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          seed_we = 1'b0;
  logic [0:0]    seed_row = '0;
  logic [W-1:0]  seed_data = '0;
  logic          start = 1'b0;
  logic [0:0]    rd_row = '0;
  logic [W-1:0]  rd_data;
  logic          busy, gen_done, frame_err;
  logic [15:0]   generation;
  logic          M_AXIS_TVALID, M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b0;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TLAST = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic          S_AXIS_TREADY;

  always #5 ACLK = ~ACLK;

  conware_board_streamer #(
    .DWIDTH (DW), .WIDTH (W), .HEIGHT (H),
    .ALIVE_COLOR (ALIVE), .DEAD_COLOR (DEAD)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .seed_we (seed_we), .seed_row (seed_row), .seed_data (seed_data),
    .start (start), .rd_row (rd_row), .rd_data (rd_data),
    .busy (busy), .gen_done (gen_done), .generation (generation),
    .frame_err (frame_err),
    .M_AXIS_TVALID (M_AXIS_TVALID), .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA), .M_AXIS_TLAST (M_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID), .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA (S_AXIS_TDATA), .S_AXIS_TLAST (S_AXIS_TLAST)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] cur_m [H];
  logic [W-1:0] nb [H];
  logic [15:0]  gen_m;
  bit           err_m;
  logic [32:0]  exp_q [$];
  logic [32:0]  tx_log [$];
  logic [31:0]  rx_d [$];
  bit           rx_l [$];

  logic [32:0] lit_tx [8] = '{
    {1'b0, 32'h00FF_FFFF}, {1'b0, 32'h0}, {1'b0, 32'h00FF_FFFF},
    {1'b1, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h0}, {1'b0, 32'h0},
    {1'b1, 32'h0}
  };

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // Per-cycle TX stream checker.
  bit          stalled = 1'b0;
  logic [32:0] held;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (!busy) begin
        chk("idle_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("idle_tready", 64'(S_AXIS_TREADY), 64'd0);
      end
      if (M_AXIS_TVALID) begin
        if (stalled) chk("stall_hold", {M_AXIS_TLAST, M_AXIS_TDATA}, held);
        if (exp_q.size() == 0) begin
          fail("tx_extra_pixel");
        end else begin
          chk("tx_pixel", {M_AXIS_TLAST, M_AXIS_TDATA}, exp_q[0]);
          if (M_AXIS_TREADY) begin
            void'(exp_q.pop_front());
            tx_log.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
          end
        end
        stalled = !M_AXIS_TREADY;
        held = {M_AXIS_TLAST, M_AXIS_TDATA};
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Next board from the return stream: each beat fills the next cell of the
  // current row; a row closes on TLAST or on its last column.
  function automatic void model_rx();
    int r = 0;
    int c = 0;
    for (int i = 0; i < H; i++) nb[i] = '0;
    err_m = 1'b0;
    for (int i = 0; i < rx_d.size(); i++) begin
      if (r >= H) break;
      nb[r][c] = (rx_d[i] != DEAD);
      if (rx_l[i] || c == W - 1) begin
        if (rx_l[i] != (c == W - 1)) err_m = 1'b1;
        r++;
        c = 0;
      end else begin
        c++;
      end
    end
  endfunction

  function automatic logic [31:0] live_px();
    return ($urandom_range(0, 1) == 1) ? ALIVE : ($urandom() | 32'h1);
  endfunction

  function automatic void build_rx(input bit errs);
    rx_d.delete();
    rx_l.delete();
    for (int r = 0; r < H; r++) begin
      int kind = errs ? int'($urandom_range(0, 3)) : 0;
      int n = (kind == 1) ? int'($urandom_range(1, W - 1)) : W;
      for (int c = 0; c < n; c++) begin
        rx_d.push_back(($urandom_range(0, 1) == 1) ? live_px() : DEAD);
        rx_l.push_back((kind == 2) ? 1'b0 : (c == n - 1));
      end
    end
    model_rx();
  endfunction

  task automatic seed(input int r, input logic [W-1:0] v);
    @(posedge ACLK); #1;
    seed_we = 1'b1;
    seed_row = 1'(r);
    seed_data = v;
    cur_m[r] = v;
    @(posedge ACLK); #1;
    seed_we = 1'b0;
  endtask

  task automatic do_start(input bit with_seed);
    @(posedge ACLK); #1;
    start = 1'b1;
    if (with_seed) begin
      int r = int'($urandom_range(0, H - 1));
      seed_we = 1'b1;
      seed_row = 1'(r);
      seed_data = W'($urandom());
      cur_m[r] = seed_data;
    end
    exp_q.delete();
    tx_log.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({(c == W - 1), cur_m[r][c] ? ALIVE : DEAD});
    @(posedge ACLK); #1;
    start = 1'b0;
    seed_we = 1'b0;
  endtask

  task automatic run_gen(input int rmode, input bit gaps, input bit poke);
    bit fin = 1'b0;
    int cnt = 0;
    int cyc = 0;
    fork
      begin
        bit t = 1'b1;
        while (!fin) begin
          case (rmode)
            0: M_AXIS_TREADY = 1'b1;
            1: M_AXIS_TREADY = t;
            default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
          endcase
          t = !t;
          @(posedge ACLK); #1;
        end
        M_AXIS_TREADY = 1'b0;
      end
      begin
        for (int i = 0; i < rx_d.size(); i++) begin
          int k = 0;
          if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge ACLK); #1;
          end
          S_AXIS_TVALID = 1'b1;
          S_AXIS_TDATA = rx_d[i];
          S_AXIS_TLAST = rx_l[i];
          forever begin
            bit acc;
            @(negedge ACLK);
            acc = S_AXIS_TREADY;
            @(posedge ACLK); #1;
            k++;
            if (acc || k > 100) break;
          end
          S_AXIS_TVALID = 1'b0;
          S_AXIS_TLAST = 1'b0;
          if (k > 100) break;
        end
      end
      begin
        while (cyc < 300) begin
          @(negedge ACLK);
          cyc++;
          if (gen_done) cnt++;
          if (poke && cyc == 3) begin
            start = 1'b1;
            seed_we = 1'b1;
            seed_row = 1'b0;
            seed_data = ~cur_m[0];
          end else if (poke && cyc == 4) begin
            start = 1'b0;
            seed_we = 1'b0;
          end
          if (cnt > 0 && !busy) break;
        end
        fin = 1'b1;
      end
    join
    chk("gen_done_pulses", 64'(cnt), 64'd1);
    for (int r = 0; r < H; r++) cur_m[r] = nb[r];
    gen_m = gen_m + 16'd1;
    chk("generation", 64'(generation), 64'(gen_m));
    chk("frame_err", 64'(frame_err), 64'(err_m));
    chk("tx_remaining", 64'(exp_q.size()), 64'd0);
    for (int r = 0; r < H; r++) begin
      rd_row = 1'(r);
      #1;
      chk("rd_data", 64'(rd_data), 64'(cur_m[r]));
    end
  endtask

  task automatic chk_tx_literal(input string nm);
    chk({nm, "_len"}, 64'(tx_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++)
      chk(nm, 64'(tx_log[i]), 64'(lit_tx[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    bit saw;
    for (int r = 0; r < H; r++) cur_m[r] = '0;
    gen_m = '0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gen_done", 64'(gen_done), 64'd0);
    chk("rst_generation", 64'(generation), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    chk("rst_tlast", 64'(M_AXIS_TLAST), 64'd0);
    chk("rst_tdata", 64'(M_AXIS_TDATA), 64'(DEAD));
    for (int r = 0; r < H; r++) begin
      rd_row = 1'(r);
      #1;
      chk("rst_rd_data", 64'(rd_data), 64'd0);
    end

    // Directed: checkerboard row 0, well-formed return stream.
    seed(0, 4'b0101);
    rx_d = '{DEAD, ALIVE, DEAD, ALIVE, DEAD, DEAD, DEAD, DEAD};
    rx_l = '{0, 0, 0, 1, 0, 0, 0, 1};
    model_rx();
    do_start(1'b0);
    run_gen(0, 1'b0, 1'b0);
    chk_tx_literal("tx_seq_ready");
    rd_row = 1'b0;
    #1;
    chk("lit_row0", 64'(rd_data), 64'(4'b1010));
    chk("lit_frame_err0", 64'(frame_err), 64'd0);
    chk("lit_gen1", 64'(generation), 64'd1);

    // Same board with TREADY toggling every cycle.
    seed(0, 4'b0101);
    model_rx();
    do_start(1'b0);
    run_gen(1, 1'b0, 1'b0);
    chk_tx_literal("tx_seq_toggle");

    // Early TLAST on the third pixel of row 0.
    rx_d = '{ALIVE, ALIVE, ALIVE, ALIVE, DEAD, DEAD, DEAD};
    rx_l = '{0, 0, 1, 0, 0, 0, 1};
    model_rx();
    do_start(1'b0);
    run_gen(0, 1'b0, 1'b0);
    chk("lit_ferr_set", 64'(frame_err), 64'd1);
    rd_row = 1'b0;
    #1;
    chk("lit_short_row0", 64'(rd_data), 64'(4'b0111));
    rd_row = 1'b1;
    #1;
    chk("lit_short_row1", 64'(rd_data), 64'(4'b0001));

    // Accepted start clears frame_err; start/seed mid-run ignored.
    build_rx(1'b0);
    do_start(1'b0);
    chk("lit_ferr_clear", 64'(frame_err), 64'd0);
    run_gen(2, 1'b1, 1'b1);

    // Reset in the middle of a run.
    do_start(1'b0);
    M_AXIS_TREADY = 1'b1;
    repeat (2) begin
      @(posedge ACLK); #1;
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    M_AXIS_TREADY = 1'b0;
    exp_q.delete();
    for (int r = 0; r < H; r++) cur_m[r] = '0;
    gen_m = '0;
    chk("midrst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("midrst_generation", 64'(generation), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    for (int r = 0; r < H; r++) begin
      rd_row = 1'(r);
      #1;
      chk("midrst_rd_data", 64'(rd_data), 64'd0);
    end
    saw = 1'b0;
    repeat (6) begin
      @(negedge ACLK);
      if (gen_done) saw = 1'b1;
    end
    chk("midrst_no_gen_done", 64'(saw), 64'd0);

    // Generation counter wrap.
    @(negedge ACLK);
    dut.gen_count = 16'hFFFF;
    gen_m = 16'hFFFF;
    build_rx(1'b0);
    do_start(1'b0);
    run_gen(0, 1'b0, 1'b0);
    chk("lit_gen_wrap", 64'(generation), 64'd0);

    // Random generations.
    for (int g = 0; g < 30; g++) begin
      if ($urandom_range(0, 2) == 0)
        seed(int'($urandom_range(0, H - 1)), W'($urandom()));
      build_rx(1'($urandom_range(0, 1)));
      do_start(1'($urandom_range(0, 1)));
      run_gen(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
